// File: rtl/bist_response_analyzer.sv
// bist_response_analyzer
// Response-side scan BIST controller. Drives scan_en through load, capture and
// unload phases, folds the serial scan_out stream into an 8-bit MISR, and
// compares the final signature against GOLDEN_SIG.
module bist_response_analyzer #(
   parameter int unsigned CHAIN_LEN    = 8,
   parameter int unsigned NUM_PATTERNS = 16,
   parameter logic [7:0]  POLY         = 8'h1D,
   parameter logic [7:0]  GOLDEN_SIG   = 8'h00
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic                              scan_out,
   output logic                              scan_en,
   output logic                              busy,
   output logic                              done,
   output logic                              pass,
   output logic [7:0]                        signature,
   output logic [$clog2(NUM_PATTERNS+1)-1:0] pat_cnt
);

   localparam int unsigned PW = $clog2(NUM_PATTERNS + 1);
   localparam int unsigned BW = $clog2(CHAIN_LEN);

   localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);
   localparam logic [PW-1:0] PAT_LAST = PW'(NUM_PATTERNS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_CAPTURE,
      ST_COMPARE,
      ST_DONE
   } state_e;

   state_e        state_q,   state_d;
   logic [7:0]    sig_q,     sig_d;
   logic [PW-1:0] pat_cnt_q, pat_cnt_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic          pass_q,    pass_d;

   // Next-state, counter, MISR and verdict logic
   always_comb begin
      state_d   = state_q;
      sig_d     = sig_q;
      pat_cnt_d = pat_cnt_q;
      bit_cnt_d = bit_cnt_q;
      pass_d    = pass_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_SHIFT;
               sig_d     = '0;
               pat_cnt_d = '0;
               bit_cnt_d = '0;
               pass_d    = 1'b0;
            end
         end
         ST_SHIFT: begin
            // the initial load unloads no captured response, so skip compression
            if (pat_cnt_q != '0) begin
               sig_d = {sig_q[6:0], 1'b0} ^ (sig_q[7] ? POLY : '0) ^ {7'b0, scan_out};
            end
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d = '0;
               state_d   = (pat_cnt_q == PAT_LAST) ? ST_COMPARE : ST_CAPTURE;
            end else begin
               bit_cnt_d = bit_cnt_q + BW'(1);
            end
         end
         ST_CAPTURE: begin
            pat_cnt_d = pat_cnt_q + PW'(1);
            state_d   = ST_SHIFT;
         end
         ST_COMPARE: begin
            pass_d  = (sig_q == GOLDEN_SIG);
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         sig_q     <= '0;
         pat_cnt_q <= '0;
         bit_cnt_q <= '0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sig_q     <= sig_d;
         pat_cnt_q <= pat_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         pass_q    <= pass_d;
      end
   end

   // Moore outputs decoded from registered state
   always_comb begin
      scan_en   = (state_q == ST_SHIFT);
      busy      = (state_q == ST_SHIFT) || (state_q == ST_CAPTURE) || (state_q == ST_COMPARE);
      done      = (state_q == ST_DONE);
      pass      = pass_q;
      signature = sig_q;
      pat_cnt   = pat_cnt_q;
   end

endmodule
